ifu: RTL and testbench

Instruction fetch unit: owns the architectural PC, fetches one 32-bit instruction at a time from the instruction-memory port and presents `{pc, inst}` to the decode stage through a valid/ready handshake. Accepts redirects (taken branches, jumps, trap/return targets) from downstream and discards any in-flight fetch on the wrong path. It sits directly upstream of the decoder and is non-pipelined: at most one outstanding memory request.

---
 rtl/ifu_if.sv | 30 +++
 rtl/ifu.sv | 116 +++++++++++
 tb/tb_ifu.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ifu_if.sv
// Fetch-unit bus bundle: instruction-memory port, redirect input and the decode-side handshake.
interface ifu_if #(
   parameter int WIDTH = 64
);
   logic             imem_req_valid;
   logic             imem_req_ready;
   logic [WIDTH-1:0] imem_addr;
   logic             imem_resp_valid;
   logic [31:0]      imem_resp_data;
   logic             imem_resp_err;
   logic             redirect_valid;
   logic [WIDTH-1:0] redirect_pc;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_pc;
   logic [31:0]      out_inst;
   logic             out_fault;

   modport master (
      output imem_req_valid, imem_addr, out_valid, out_pc, out_inst, out_fault,
      input  imem_req_ready, imem_resp_valid, imem_resp_data, imem_resp_err,
             redirect_valid, redirect_pc, out_ready
   );

   modport slave (
      input  imem_req_valid, imem_addr, out_valid, out_pc, out_inst, out_fault,
      output imem_req_ready, imem_resp_valid, imem_resp_data, imem_resp_err,
             redirect_valid, redirect_pc, out_ready
   );
endinterface

// File: rtl/ifu.sv
// Non-pipelined instruction fetch unit: owns the PC, keeps one memory request in flight,
// buffers the fetched word for decode and squashes wrong-path responses after a redirect.
module ifu #(
   parameter int               WIDTH    = 64,
   parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(64'h8000_0000)
) (
   input logic   clk,
   input logic   rst,
   ifu_if.master bus
);

   typedef enum logic [1:0] {REQ, WAIT, HOLD, STOP} state_t;

   state_t           state, state_n;
   logic [WIDTH-1:0] pc, pc_n;
   logic             kill, kill_n;
   logic             misaligned;
   logic             load;
   logic [31:0]      load_inst;
   logic             load_fault;
   logic [WIDTH-1:0] buf_pc;
   logic [31:0]      buf_inst;
   logic             buf_fault;

   assign misaligned = (pc[1:0] != 2'b00);

   // A redirect outranks every other transition; in WAIT it cannot abandon the outstanding
   // request, so it marks it killed and the response is dropped when it arrives.
   always_comb begin
      state_n    = state;
      pc_n       = pc;
      kill_n     = kill;
      load       = 1'b0;
      load_inst  = '0;
      load_fault = 1'b0;
      case (state)
         REQ: begin
            if (bus.redirect_valid) begin
               pc_n = bus.redirect_pc;
            end else if (misaligned) begin
               load       = 1'b1;
               load_fault = 1'b1;
               state_n    = HOLD;
            end else if (bus.imem_req_ready) begin
               state_n = WAIT;
            end
         end
         WAIT: begin
            if (bus.imem_resp_valid) begin
               kill_n  = 1'b0;
               state_n = REQ;
               if (bus.redirect_valid) begin
                  pc_n = bus.redirect_pc;
               end else if (!kill) begin
                  load       = 1'b1;
                  load_inst  = bus.imem_resp_err ? 32'h0 : bus.imem_resp_data;
                  load_fault = bus.imem_resp_err;
                  state_n    = HOLD;
               end
            end else if (bus.redirect_valid) begin
               pc_n   = bus.redirect_pc;
               kill_n = 1'b1;
            end
         end
         HOLD: begin
            if (bus.redirect_valid) begin
               pc_n    = bus.redirect_pc;
               state_n = REQ;
            end else if (bus.out_ready) begin
               if (buf_fault) begin
                  state_n = STOP;
               end else begin
                  pc_n    = pc + WIDTH'(4);
                  state_n = REQ;
               end
            end
         end
         STOP: begin
            if (bus.redirect_valid) begin
               pc_n    = bus.redirect_pc;
               state_n = REQ;
            end
         end
         default: state_n = REQ;
      endcase
   end

   // State, PC and kill flag; the output buffer only changes on a load, so it is stable in HOLD.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= REQ;
         pc        <= RESET_PC;
         kill      <= 1'b0;
         buf_pc    <= '0;
         buf_inst  <= '0;
         buf_fault <= 1'b0;
      end else begin
         state <= state_n;
         pc    <= pc_n;
         kill  <= kill_n;
         if (load) begin
            buf_pc    <= pc;
            buf_inst  <= load_inst;
            buf_fault <= load_fault;
         end
      end
   end

   assign bus.imem_req_valid = !rst && (state == REQ) && !misaligned && !bus.redirect_valid;
   assign bus.imem_addr      = pc;
   assign bus.out_valid      = (state == HOLD);
   assign bus.out_pc         = buf_pc;
   assign bus.out_inst       = buf_inst;
   assign bus.out_fault      = buf_fault;

endmodule

// File: tb/tb_ifu.sv
// Self-checking bench for ifu: directed scenarios against a memory responder and a
// per-cycle behavioural model of the architectural fetch stream.
module tb_ifu;

   localparam logic [63:0] RESET_PC = 64'h8000_0000;
   localparam logic [63:0] NO_ERR   = 64'hFFFF_FFFF_FFFF_FFF0;

   logic clk;
   logic rst;

   ifu_if #(.WIDTH(64)) bus ();

   ifu #(.WIDTH(64), .RESET_PC(RESET_PC)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.master)
   );

   int          errors = 0;
   int          checks = 0;
   int          cyc    = 0;
   int          lat    = 1;
   logic [63:0] err_addr = NO_ERR;

   logic [63:0] hs_pc[$];
   logic [31:0] hs_inst[$];
   logic        hs_fault[$];
   int          hs_cyc[$];
   logic [63:0] req_log[$];
   int          req_count = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [63:0] a);
      return a[31:0] ^ 32'h1357_9BDF;
   endfunction

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Memory responder: accepts on the edge, answers lat cycles later, forgets everything on reset.
   logic        m_pend = 1'b0;
   logic [63:0] m_addr = '0;
   int          m_cnt  = 0;
   always @(posedge clk) begin
      logic        acc;
      logic [63:0] a;
      acc = bus.imem_req_valid && bus.imem_req_ready;
      a   = bus.imem_addr;
      #1;
      bus.imem_resp_valid = 1'b0;
      bus.imem_resp_data  = 32'h0;
      bus.imem_resp_err   = 1'b0;
      if (rst) begin
         m_pend = 1'b0;
      end else begin
         if (acc) begin
            m_pend = 1'b1;
            m_addr = a;
            m_cnt  = lat;
            req_count++;
            req_log.push_back(a);
         end
         if (m_pend) begin
            if (m_cnt <= 1) begin
               bus.imem_resp_valid = 1'b1;
               bus.imem_resp_data  = mem_word(m_addr);
               bus.imem_resp_err   = (m_addr == err_addr);
               m_pend              = 1'b0;
            end else begin
               m_cnt--;
            end
         end
      end
   end

   // Model: the fetch stream is exp_pc, exp_pc+4, ... restarted by redirects, halted after a fault.
   logic [63:0] exp_pc  = RESET_PC;
   logic        stopped = 1'b0;
   logic        prev_hold = 1'b0;
   logic [63:0] prev_pc;
   logic [31:0] prev_inst;
   logic        prev_fault;
   always @(posedge clk) begin
      logic        exp_fault;
      logic [31:0] exp_inst;
      #8;
      cyc++;
      if (rst) begin
         checkOutput("rst_out_valid", 64'(bus.out_valid), 64'd0);
         checkOutput("rst_req_valid", 64'(bus.imem_req_valid), 64'd0);
         checkOutput("rst_out_pc", bus.out_pc, 64'd0);
         checkOutput("rst_out_inst", 64'(bus.out_inst), 64'd0);
         checkOutput("rst_out_fault", 64'(bus.out_fault), 64'd0);
         exp_pc    = RESET_PC;
         stopped   = 1'b0;
         prev_hold = 1'b0;
      end else begin
         exp_fault = (exp_pc[1:0] != 2'b00) || (exp_pc == err_addr);
         exp_inst  = exp_fault ? 32'h0 : mem_word(exp_pc);
         if (bus.imem_req_valid) checkOutput("req_addr", bus.imem_addr, exp_pc);
         if (bus.redirect_valid) checkOutput("req_on_redirect", 64'(bus.imem_req_valid), 64'd0);
         checkOutput("req_misaligned", 64'(bus.imem_req_valid && exp_pc[1:0] != 2'b00), 64'd0);
         checkOutput("req_idle", 64'(bus.imem_req_valid && (stopped || bus.out_valid)), 64'd0);
         if (stopped) checkOutput("stop_out_valid", 64'(bus.out_valid), 64'd0);
         if (prev_hold) begin
            checkOutput("stable_valid", 64'(bus.out_valid), 64'd1);
            checkOutput("stable_pc", bus.out_pc, prev_pc);
            checkOutput("stable_inst", 64'(bus.out_inst), 64'(prev_inst));
            checkOutput("stable_fault", 64'(bus.out_fault), 64'(prev_fault));
         end
         if (bus.out_valid) begin
            checkOutput("out_pc", bus.out_pc, exp_pc);
            checkOutput("out_inst", 64'(bus.out_inst), 64'(exp_inst));
            checkOutput("out_fault", 64'(bus.out_fault), 64'(exp_fault));
         end
         prev_hold  = bus.out_valid && !bus.out_ready && !bus.redirect_valid;
         prev_pc    = bus.out_pc;
         prev_inst  = bus.out_inst;
         prev_fault = bus.out_fault;
         if (bus.redirect_valid) begin
            exp_pc  = bus.redirect_pc;
            stopped = 1'b0;
         end else if (bus.out_valid && bus.out_ready) begin
            hs_pc.push_back(bus.out_pc);
            hs_inst.push_back(bus.out_inst);
            hs_fault.push_back(bus.out_fault);
            hs_cyc.push_back(cyc);
            if (exp_fault) stopped = 1'b1;
            else exp_pc = exp_pc + 64'd4;
         end
      end
   end

   task automatic waitCycles(input int n);
      repeat (n) begin
         @(posedge clk);
         #3;
      end
   endtask

   task automatic clearLogs();
      hs_pc.delete();
      hs_inst.delete();
      hs_fault.delete();
      hs_cyc.delete();
      req_log.delete();
   endtask

   // One-cycle redirect pulse; logs restart so later checks see only the new path.
   task automatic applyStimulus(input logic [63:0] target);
      clearLogs();
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = target;
      waitCycles(1);
      bus.redirect_valid = 1'b0;
   endtask

   task automatic waitHandshakes(input int n, input int budget, input string name);
      int k = 0;
      while (hs_pc.size() < n && k < budget) begin
         waitCycles(1);
         k++;
      end
      checkOutput({name, "_timeout"}, 64'(hs_pc.size() >= n), 64'd1);
   endtask

   task automatic waitRequest(input int budget, input string name);
      int snap = req_count;
      int k = 0;
      while (req_count == snap && k < budget) begin
         waitCycles(1);
         k++;
      end
      checkOutput({name, "_timeout"}, 64'(req_count != snap), 64'd1);
   endtask

   initial begin
      int snap;
      int k;
      rst                = 1'b1;
      bus.imem_req_ready = 1'b1;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc    = '0;
      bus.out_ready      = 1'b1;
      repeat (3) @(posedge clk);
      #3;
      rst = 1'b0;
      #1;
      checkOutput("first_req_valid", 64'(bus.imem_req_valid), 64'd1);
      checkOutput("first_req_addr", bus.imem_addr, RESET_PC);

      // Streaming with a 1-cycle memory: one instruction every third cycle
      waitHandshakes(3, 30, "stream");
      checkOutput("stream_pc0", hs_pc[0], 64'h8000_0000);
      checkOutput("stream_pc1", hs_pc[1], 64'h8000_0004);
      checkOutput("stream_pc2", hs_pc[2], 64'h8000_0008);
      checkOutput("stream_inst0", 64'(hs_inst[0]), 64'h9357_9BDF);
      checkOutput("stream_inst1", 64'(hs_inst[1]), 64'h9357_9BDB);
      checkOutput("stream_gap01", 64'(hs_cyc[1] - hs_cyc[0]), 64'd3);
      checkOutput("stream_gap12", 64'(hs_cyc[2] - hs_cyc[1]), 64'd3);

      // Back-pressure: decode stalls for 5 cycles while an instruction is presented
      bus.out_ready = 1'b0;
      k = 0;
      while (!bus.out_valid && k < 20) begin
         waitCycles(1);
         k++;
      end
      checkOutput("stall_valid", 64'(bus.out_valid), 64'd1);
      checkOutput("stall_pc", bus.out_pc, 64'h8000_000C);
      snap = req_count;
      waitCycles(5);
      checkOutput("stall_noreq", 64'(req_count), 64'(snap));
      checkOutput("stall_pc_after", bus.out_pc, 64'h8000_000C);
      lat = 4;
      bus.out_ready = 1'b1;
      waitRequest(20, "stall_release");
      checkOutput("stall_next_addr", req_log[$], 64'h8000_0010);

      // Redirect while the 4-cycle fetch of 8000_0010 is still outstanding
      applyStimulus(64'h8000_0100);
      waitHandshakes(1, 40, "kill");
      checkOutput("kill_pc", hs_pc[0], 64'h8000_0100);
      checkOutput("kill_inst", 64'(hs_inst[0]), 64'h9357_9ADF);
      checkOutput("kill_req_addr", req_log[0], 64'h8000_0100);
      lat = 1;

      // Misaligned target: fault presented without a request, then the unit parks
      applyStimulus(64'h8000_0102);
      waitHandshakes(1, 20, "misalign");
      checkOutput("misalign_pc", hs_pc[0], 64'h8000_0102);
      checkOutput("misalign_fault", 64'(hs_fault[0]), 64'd1);
      checkOutput("misalign_inst", 64'(hs_inst[0]), 64'd0);
      waitCycles(6);
      checkOutput("misalign_noreq", 64'(req_log.size()), 64'd0);
      checkOutput("stop_no_out", 64'(hs_pc.size()), 64'd1);
      applyStimulus(64'h8000_0200);
      waitHandshakes(1, 20, "resume");
      checkOutput("resume_pc", hs_pc[0], 64'h8000_0200);
      checkOutput("resume_req_addr", req_log[0], 64'h8000_0200);

      // Access fault on 8000_0008, with the memory briefly not ready
      err_addr = 64'h8000_0008;
      bus.imem_req_ready = 1'b0;
      applyStimulus(64'h8000_0000);
      waitCycles(3);
      bus.imem_req_ready = 1'b1;
      waitHandshakes(3, 40, "err");
      checkOutput("err_fault0", 64'(hs_fault[0]), 64'd0);
      checkOutput("err_pc2", hs_pc[2], 64'h8000_0008);
      checkOutput("err_fault2", 64'(hs_fault[2]), 64'd1);
      checkOutput("err_inst2", 64'(hs_inst[2]), 64'd0);
      waitCycles(5);
      checkOutput("err_stop_noreq", 64'(req_log.size()), 64'd3);

      // Reset in the middle of an outstanding fetch
      err_addr = NO_ERR;
      lat = 4;
      applyStimulus(64'h8000_0000);
      waitRequest(20, "rst_wait");
      waitCycles(1);
      rst = 1'b1;
      #1;
      checkOutput("async_out_valid", 64'(bus.out_valid), 64'd0);
      checkOutput("async_req_valid", 64'(bus.imem_req_valid), 64'd0);
      checkOutput("async_out_pc", bus.out_pc, 64'd0);
      checkOutput("async_out_fault", 64'(bus.out_fault), 64'd0);
      #1;
      waitCycles(2);
      lat = 1;
      clearLogs();
      rst = 1'b0;
      #1;
      checkOutput("rerst_req_valid", 64'(bus.imem_req_valid), 64'd1);
      checkOutput("rerst_req_addr", bus.imem_addr, RESET_PC);
      waitHandshakes(1, 20, "rerst");
      checkOutput("rerst_pc", hs_pc[0], RESET_PC);
      checkOutput("rerst_inst", 64'(hs_inst[0]), 64'h9357_9BDF);
      checkOutput("rerst_first_req", req_log[0], RESET_PC);

      waitCycles(2);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
